// File: rtl/lbp_result_writer.sv
// Result writer for the LBP engine: queues interior results in a small FIFO,
// commits them over a req/ack memory port, then writes the 508 image border pixels.
module lbp_result_writer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  BORDER_VAL = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] lbp_addr,
    input  logic        lbp_valid,
    input  logic [7:0]  lbp_data,
    input  logic        lbp_finish,
    output logic [13:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wen,
    input  logic        mem_ack,
    output logic        ovf,
    output logic        done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FLUSH  = 2'd1,
        S_BORDER = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e       state_q;
    logic         finish_q;
    logic         ovf_q;
    logic         done_q;
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [1:0]   seg_q;
    logic [6:0]   pos_q;
    logic [13:0]  fifo_addr_q [FIFO_DEPTH];
    logic [7:0]   fifo_data_q [FIFO_DEPTH];

    logic         fifo_empty_s;
    logic         fifo_full_s;
    logic         fifo_src_s;
    logic         push_s;
    logic         pop_s;
    logic         drop_s;
    logic [13:0]  border_addr_s;

    // Segments: 0 top row, 1 bottom row, 2 left column, 3 right column.
    function automatic logic [13:0] border_addr(input logic [1:0] seg, input logic [6:0] pos);
        logic [13:0] a;
        case (seg)
            2'd0:    a = {7'd0, pos};
            2'd1:    a = {7'd127, pos};
            2'd2:    a = {pos, 7'd0};
            2'd3:    a = {pos, 7'd127};
            default: a = 14'd0;
        endcase
        return a;
    endfunction

    // FIFO status, handshake qualifiers and output port decode.
    always_comb begin
        fifo_empty_s  = (wr_ptr_q == rd_ptr_q);
        fifo_full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        fifo_src_s    = (state_q == S_RUN) || (state_q == S_FLUSH);
        pop_s         = fifo_src_s && !fifo_empty_s && mem_ack;
        push_s        = lbp_valid && (state_q == S_RUN) && (!fifo_full_s || pop_s);
        drop_s        = lbp_valid && !push_s;
        border_addr_s = border_addr(seg_q, pos_q);
        mem_wen       = 1'b0;
        mem_addr      = 14'd0;
        mem_wdata     = 8'd0;
        if (state_q == S_BORDER) begin
            mem_wen   = 1'b1;
            mem_addr  = border_addr_s;
            mem_wdata = BORDER_VAL;
        end else if (fifo_src_s && !fifo_empty_s) begin
            mem_wen   = 1'b1;
            mem_addr  = fifo_addr_q[rd_ptr_q[AW-1:0]];
            mem_wdata = fifo_data_q[rd_ptr_q[AW-1:0]];
        end else begin
            mem_wen   = 1'b0;
        end
        ovf  = ovf_q;
        done = done_q;
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_q[wr_ptr_q[AW-1:0]] <= lbp_addr;
            fifo_data_q[wr_ptr_q[AW-1:0]] <= lbp_data;
        end
    end

    // Control FSM, FIFO pointers, border generator and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RUN;
            finish_q <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            seg_q    <= 2'd0;
            pos_q    <= 7'd0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (drop_s) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                S_RUN: begin
                    if (lbp_finish) begin
                        finish_q <= 1'b1;
                    end
                    if (finish_q) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (fifo_empty_s) begin
                        state_q <= S_BORDER;
                    end
                end
                S_BORDER: begin
                    if (mem_ack) begin
                        case (seg_q)
                            2'd0: begin
                                if (pos_q == 7'd127) begin
                                    seg_q <= 2'd1;
                                    pos_q <= 7'd0;
                                end else begin
                                    pos_q <= pos_q + 7'd1;
                                end
                            end
                            2'd1: begin
                                // Columns skip the corners already written by the rows.
                                if (pos_q == 7'd127) begin
                                    seg_q <= 2'd2;
                                    pos_q <= 7'd1;
                                end else begin
                                    pos_q <= pos_q + 7'd1;
                                end
                            end
                            2'd2: begin
                                if (pos_q == 7'd126) begin
                                    seg_q <= 2'd3;
                                    pos_q <= 7'd1;
                                end else begin
                                    pos_q <= pos_q + 7'd1;
                                end
                            end
                            default: begin
                                if (pos_q == 7'd126) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    pos_q <= pos_q + 7'd1;
                                end
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_result_writer.sv
// Directed self-checking bench for lbp_result_writer (FIFO_DEPTH=4, BORDER_VAL=0).
module tb_lbp_result_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] lbp_addr;
    logic        lbp_valid;
    logic [7:0]  lbp_data;
    logic        lbp_finish;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ack;
    logic        ovf;
    logic        done;

    int vectors = 0;
    int errors  = 0;

    logic [13:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    byte unsigned hits [16384];

    lbp_result_writer #(.FIFO_DEPTH(4), .BORDER_VAL(8'd0)) dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_addr   (lbp_addr),
        .lbp_valid  (lbp_valid),
        .lbp_data   (lbp_data),
        .lbp_finish (lbp_finish),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_ack    (mem_ack),
        .ovf        (ovf),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records the write presented this cycle (committed at the next edge with ack=1).
    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            if (mem_wen) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
            end
            tick();
            n++;
        end
        check("done_within_budget", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int bad;
        int nz;
        int n;
        reset = 1'b1; lbp_addr = 14'd0; lbp_valid = 1'b0; lbp_data = 8'd0;
        lbp_finish = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        check("rst_wen",   {31'd0, mem_wen}, 32'd0);
        check("rst_addr",  {18'd0, mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_ovf",   {31'd0, ovf}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();

        // Single result with ack tied high
        mem_ack = 1'b1;
        lbp_valid = 1'b1; lbp_addr = 14'd129; lbp_data = 8'h5A;
        tick();
        lbp_valid = 1'b0;
        check("single_wen",   {31'd0, mem_wen}, 32'd1);
        check("single_addr",  {18'd0, mem_addr}, 32'd129);
        check("single_wdata", {24'd0, mem_wdata}, 32'h5A);
        tick();
        check("single_after_wen", {31'd0, mem_wen}, 32'd0);

        // Backpressure: three pushes 10 cycles apart, ack low for 25 cycles
        mem_ack = 1'b0;
        lbp_valid = 1'b1; lbp_addr = 14'd300; lbp_data = 8'h11;
        tick();
        lbp_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 9) begin
                lbp_valid = 1'b1; lbp_addr = 14'd301; lbp_data = 8'h22;
            end else if (i == 19) begin
                lbp_valid = 1'b1; lbp_addr = 14'd302; lbp_data = 8'h33;
            end else begin
                lbp_valid = 1'b0;
            end
            tick();
            if (!(mem_wen === 1'b1 && mem_addr === 14'd300 && mem_wdata === 8'h11)) bad++;
        end
        lbp_valid = 1'b0;
        check("stall_stable", bad, 32'd0);
        mem_ack = 1'b1;
        tick();
        check("bp_w2_addr",  {18'd0, mem_addr}, 32'd301);
        check("bp_w2_wdata", {24'd0, mem_wdata}, 32'h22);
        tick();
        check("bp_w3_wen",   {31'd0, mem_wen}, 32'd1);
        check("bp_w3_addr",  {18'd0, mem_addr}, 32'd302);
        check("bp_w3_wdata", {24'd0, mem_wdata}, 32'h33);
        tick();
        check("bp_empty_wen", {31'd0, mem_wen}, 32'd0);
        check("bp_ovf",       {31'd0, ovf}, 32'd0);

        // Overflow: five pushes into a four-entry FIFO with ack low
        mem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lbp_valid = 1'b1; lbp_addr = 14'd400 + 14'(k); lbp_data = 8'h40 + 8'(k);
            tick();
        end
        lbp_valid = 1'b0;
        check("ovf_set", {31'd0, ovf}, 32'd1);
        tick(); tick(); tick();
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        mem_ack = 1'b1;
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 10; i++) begin
            if (mem_wen) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
            end
            tick();
        end
        check("ovf_write_count", wr_addr.size(), 32'd4);
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
            if (wr_addr[i] !== 14'd400 + 14'(i) || wr_data[i] !== 8'h40 + 8'(i)) bad++;
        end
        check("ovf_write_order", bad, 32'd0);
        check("ovf_still_set", {31'd0, ovf}, 32'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_clears_ovf", {31'd0, ovf}, 32'd0);

        // Finish with two queued entries; second arrives with lbp_finish
        mem_ack = 1'b0;
        lbp_valid = 1'b1; lbp_addr = 14'd500; lbp_data = 8'h77;
        tick();
        lbp_addr = 14'd16254; lbp_data = 8'h88; lbp_finish = 1'b1;
        tick();
        lbp_valid = 1'b0;
        tick(); tick();
        mem_ack = 1'b1;
        wr_addr.delete(); wr_data.delete();
        run_until_done(2000);
        check("fin_total_writes", wr_addr.size(), 32'd510);
        if (wr_addr.size() == 510) begin
            check("fin_int0_addr",  {18'd0, wr_addr[0]}, 32'd500);
            check("fin_int0_data",  {24'd0, wr_data[0]}, 32'h77);
            check("fin_int1_addr",  {18'd0, wr_addr[1]}, 32'd16254);
            check("fin_int1_data",  {24'd0, wr_data[1]}, 32'h88);
            check("fin_b_first",    {18'd0, wr_addr[2]}, 32'd0);
            check("fin_b_1",        {18'd0, wr_addr[3]}, 32'd1);
            check("fin_b_127",      {18'd0, wr_addr[129]}, 32'd127);
            check("fin_b_bot0",     {18'd0, wr_addr[130]}, 32'd16256);
            check("fin_b_bot127",   {18'd0, wr_addr[257]}, 32'd16383);
            check("fin_b_left1",    {18'd0, wr_addr[258]}, 32'd128);
            check("fin_b_left126",  {18'd0, wr_addr[383]}, 32'd16128);
            check("fin_b_right1",   {18'd0, wr_addr[384]}, 32'd255);
            check("fin_b_last",     {18'd0, wr_addr[509]}, 32'd16255);
            nz = 0;
            for (int i = 0; i < 16384; i++) hits[i] = 8'd0;
            for (int i = 2; i < 510; i++) begin
                if (wr_data[i] !== 8'h00) nz++;
                hits[wr_addr[i]] = hits[wr_addr[i]] + 8'd1;
            end
            check("fin_border_data", nz, 32'd0);
            bad = 0;
            for (int a = 0; a < 16384; a++) begin
                if ((a / 128 == 0 || a / 128 == 127 || a % 128 == 0 || a % 128 == 127)
                        ? (hits[a] != 8'd1) : (hits[a] != 8'd0)) bad++;
            end
            check("fin_border_cover", bad, 32'd0);
        end
        check("fin_done_wen", {31'd0, mem_wen}, 32'd0);
        check("fin_ovf_clear", {31'd0, ovf}, 32'd0);

        lbp_valid = 1'b1; lbp_addr = 14'd5; lbp_data = 8'h01;
        tick();
        lbp_valid = 1'b0;
        tick();
        check("done_valid_ovf",  {31'd0, ovf}, 32'd1);
        check("done_sticky",     {31'd0, done}, 32'd1);
        check("done_wen_low",    {31'd0, mem_wen}, 32'd0);

        // Reset while border write #200 is presented, then a full rerun
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        bad = 0;
        while (n < 199 && bad < 1000) begin
            if (mem_wen) n++;
            tick();
            bad++;
        end
        check("b200_wen",  {31'd0, mem_wen}, 32'd1);
        check("b200_addr", {18'd0, mem_addr}, 32'd16327);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_wen",   {31'd0, mem_wen}, 32'd0);
        check("midrst_addr",  {18'd0, mem_addr}, 32'd0);
        check("midrst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("midrst_done",  {31'd0, done}, 32'd0);
        tick();
        reset = 1'b0;
        wr_addr.delete(); wr_data.delete();
        run_until_done(2000);
        check("rerun_count", wr_addr.size(), 32'd508);
        if (wr_addr.size() == 508) begin
            check("rerun_first", {18'd0, wr_addr[0]}, 32'd0);
            check("rerun_last",  {18'd0, wr_addr[507]}, 32'd16255);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
